axi4lite_master: RTL

- Command-driven AXI4-Lite master that issues single read and write transactions to the 32-entry, word-addressed AXI4-Lite register slave.
- Sits directly upstream of that slave: a local client hands it one command at a time, it runs the AR/R or AW/W/B handshakes, and returns one response per command.
- A watchdog aborts any transaction the slave never completes, so a hung slave cannot lock up the client.

---
 rtl/axi4lite_pkg.sv | 38 +++
 rtl/axi4lite_if.sv | 45 ++++
 rtl/axi_watchdog.sv | 58 +++++
 rtl/axi4lite_master.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// ---------------------------------------------------------------------------
// axi4lite_pkg
//   Shared types and constants for the command-driven AXI4-Lite master:
//   response codes, word-address bounds, the master FSM encoding and a
//   helper that identifies the states in which the watchdog runs.
// ---------------------------------------------------------------------------
package axi4lite_pkg;

  // Word address occupies bits [ADDR_MSB:ADDR_LSB] of the byte address.
  localparam int ADDR_LSB = 2;
  localparam int ADDR_MSB = 6;

  typedef logic [ADDR_MSB:ADDR_LSB] word_addr_t;

  typedef logic [1:0] axi_resp_t;
  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4,
    RSP     = 3'd5
  } master_state_t;

  // True for every state that waits on a slave handshake.
  function automatic logic is_wait_state(input master_state_t s);
    logic w;
    case (s)
      RD_ADDR, RD_DATA, WR_ADDR, WR_RESP: w = 1'b1;
      default:                            w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/axi4lite_if.sv
// ---------------------------------------------------------------------------
// axi4lite_if
//   AXI4-Lite bus between the master and the 32-entry register slave.
//   Read channels : araddr/arvalid/arready, rdata/rvalid/rready
//   Write channels: awaddr/awvalid/awready, wdata/wvalid/wready,
//                   response/bvalid/bready
//   modport master: drives addresses, write data, valids and readys.
//   modport slave : the mirror image.
// ---------------------------------------------------------------------------
interface axi4lite_if;
  import axi4lite_pkg::*;

  word_addr_t  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  word_addr_t  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;

  axi_resp_t   response;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready,
    output awaddr, awvalid, wdata, wvalid, bready,
    input  arready, rdata, rvalid,
    input  awready, wready, response, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    input  awaddr, awvalid, wdata, wvalid, bready,
    output arready, rdata, rvalid,
    output awready, wready, response, bvalid
  );

endinterface

// File: rtl/axi_watchdog.sv
// ---------------------------------------------------------------------------
// axi_watchdog
//   Loadable down-counter that flags a stalled handshake.
//   clk, reset : clock and synchronous active-high reset
//   clear      : reload the counter (entry to a wait state / handshake)
//   enable     : count this cycle (master is in a wait state)
//   expire     : this is the TIMEOUT-th consecutive enabled cycle since the
//                last clear; the master aborts at this edge
//   TIMEOUT=0 removes the counter and expire is tied low.
// ---------------------------------------------------------------------------
module axi_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  if (TIMEOUT == 0) begin : g_bypass
    logic unused_s;
    assign unused_s = ^{clk, reset, clear, enable};
    assign expire   = 1'b0;
  end else begin : g_count
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Loading TIMEOUT-1 and expiring at zero is the same as an up-count
    // that fires when wait_cnt reaches TIMEOUT-1.
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: reload on clear, otherwise count down while enabled.
    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = LOAD_VAL;
      end else if (enable && (cnt_q != {CW{1'b0}})) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end

    // Counter register.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= LOAD_VAL;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign expire = enable && (cnt_q == {CW{1'b0}});
  end

endmodule

// File: rtl/axi4lite_master.sv
// ---------------------------------------------------------------------------
// axi4lite_master
//   Accepts one client command at a time, runs a single AXI4-Lite read
//   (AR/R) or write (AW/W/B) and returns one response per command.
//   A watchdog aborts any handshake that stalls for TIMEOUT cycles and
//   answers SLVERR so a hung slave cannot lock up the client.
//   clk, reset          : clock, synchronous active-high reset
//   cmd_valid/ready     : command handshake; cmd_write selects write
//   cmd_addr, cmd_wdata : word address and write data
//   rsp_valid/ready     : response handshake, held until taken
//   rsp_rdata, rsp_resp : read data (0 on writes/timeouts), response code
//   axi                 : AXI4-Lite master port
// ---------------------------------------------------------------------------
module axi4lite_master
  import axi4lite_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  word_addr_t        cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output axi_resp_t         rsp_resp,
  axi4lite_if.master        axi
);

  master_state_t state_q, state_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  axi_resp_t     rsp_resp_q, rsp_resp_d;
  word_addr_t    araddr_q, araddr_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  word_addr_t    awaddr_q, awaddr_d;
  logic          awvalid_q, awvalid_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;

  logic ar_hs_s, r_hs_s, aw_hs_s, w_hs_s, b_hs_s;
  logic wd_clear_s, wd_enable_s, wd_expire_s;
  logic timeout_s;

  assign ar_hs_s = arvalid_q && axi.arready;
  assign r_hs_s  = rready_q  && axi.rvalid;
  assign aw_hs_s = awvalid_q && axi.awready;
  assign w_hs_s  = wvalid_q  && axi.wready;
  assign b_hs_s  = bready_q  && axi.bvalid;

  assign wd_enable_s = is_wait_state(state_q);

  axi_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wd_clear_s),
    .enable (wd_enable_s),
    .expire (wd_expire_s)
  );

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    awvalid_d   = awvalid_q;
    wdata_d     = wdata_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    wd_clear_s  = 1'b0;
    timeout_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          araddr_d    = cmd_addr;
          awaddr_d    = cmd_addr;
          wdata_d     = cmd_wdata;
          cmd_ready_d = 1'b0;
          wd_clear_s  = 1'b1;
          if (cmd_write) begin
            state_d   = WR_ADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end else begin
          cmd_ready_d = 1'b1;
        end
      end

      RD_ADDR: begin
        if (ar_hs_s) begin
          state_d    = RD_DATA;
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
          wd_clear_s = 1'b1;
        end else if (wd_expire_s) begin
          timeout_s = 1'b1;
        end else begin
          state_d = RD_ADDR;
        end
      end

      RD_DATA: begin
        // The slave has no read-response code, so reads always return OKAY.
        if (r_hs_s) begin
          state_d     = RSP;
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = axi.rdata;
          rsp_resp_d  = RESP_OKAY;
        end else if (wd_expire_s) begin
          timeout_s = 1'b1;
        end else begin
          state_d = RD_DATA;
        end
      end

      WR_ADDR: begin
        // AW and W complete independently; either handshake restarts the
        // watchdog, and both may land in the same cycle.
        awvalid_d  = awvalid_q && !aw_hs_s;
        wvalid_d   = wvalid_q  && !w_hs_s;
        aw_done_d  = aw_done_q || aw_hs_s;
        w_done_d   = w_done_q  || w_hs_s;
        wd_clear_s = aw_hs_s || w_hs_s;
        if (aw_done_d && w_done_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end else if (wd_expire_s && !aw_hs_s && !w_hs_s) begin
          timeout_s = 1'b1;
        end else begin
          state_d = WR_ADDR;
        end
      end

      WR_RESP: begin
        if (b_hs_s) begin
          state_d     = RSP;
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0000_0000;
          rsp_resp_d  = axi.response;
        end else if (wd_expire_s) begin
          timeout_s = 1'b1;
        end else begin
          state_d = WR_RESP;
        end
      end

      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end else begin
          state_d = RSP;
        end
      end

      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
      end
    endcase

    // Watchdog abort: drop every AXI valid/ready and answer SLVERR.
    if (timeout_s) begin
      state_d     = RSP;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_rdata_d = 32'h0000_0000;
      rsp_resp_d  = RESP_SLVERR;
    end else begin
      rsp_resp_d  = rsp_resp_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_resp_q  <= RESP_OKAY;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= 32'h0000_0000;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      awvalid_q   <= awvalid_d;
      wdata_q     <= wdata_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign axi.araddr  = araddr_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign axi.awaddr  = awaddr_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

endmodule
